// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder: DIRECT decodes a handshaked index, SCAN steps
// through all outputs with a programmable dwell. One cycle latency; sel_ready only in DIRECT.
module decoder_scan #(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        cur_idx,
  output logic                    wrap
);

  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   idx_n;
  logic [DWELL_W-1:0] dcnt, dcnt_n;
  logic               wrap_n;
  logic [OUT_W-1:0]   out_n;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] d;
    d      = '0;
    d[idx] = 1'b1;
    return d ^ INACTIVE;
  endfunction

  // Handshake is qualified by the registered state, so a same-cycle mode change cannot open it.
  assign sel_ready = (state == DIRECT);

  always_comb begin
    state_n = state;
    idx_n   = cur_idx;
    dcnt_n  = dcnt;
    wrap_n  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      dcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = mode ? SCAN : DIRECT;
          dcnt_n  = '0;
        end
        DIRECT: begin
          if (sel_valid) idx_n = sel;
          if (mode) begin
            state_n = SCAN;
            dcnt_n  = '0;
          end
        end
        SCAN: begin
          if (!mode) begin
            state_n = DIRECT;
            dcnt_n  = '0;
          end else if (dcnt == dwell) begin
            dcnt_n = '0;
            idx_n  = cur_idx + SEL_W'(1);
            wrap_n = &cur_idx;
          end else begin
            dcnt_n = dcnt + DWELL_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
    out_n = (state_n == IDLE) ? INACTIVE : decode(idx_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_idx <= '0;
      dcnt    <= '0;
      wrap    <= 1'b0;
      out     <= INACTIVE;
    end else begin
      state   <= state_n;
      cur_idx <= idx_n;
      dcnt    <= dcnt_n;
      wrap    <= wrap_n;
      out     <= out_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: default 8-output instance plus a 16-output active-low instance,
// checked against hand-derived expectations queued per driven cycle.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, mode, sel_valid;
  logic [2:0] sel;
  logic [7:0] dwell;
  logic       sel_ready;
  logic [7:0] out;
  logic [2:0] cur_idx;
  logic       wrap;

  logic        en_b, mode_b, vld_b;
  logic [3:0]  sel_b;
  logic [7:0]  dwell_b;
  logic        rdy_b;
  logic [15:0] out_b;
  logic [3:0]  idx_b;
  logic        wrap_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] out;
    logic [3:0]  idx;
    logic        wrap;
    logic        rdy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  decoder_scan u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .dwell(dwell),
    .out(out), .cur_idx(cur_idx), .wrap(wrap)
  );

  decoder_scan #(.SEL_W(4), .DWELL_W(8), .ACTIVE_LOW(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .mode(mode_b), .sel(sel_b),
    .sel_valid(vld_b), .sel_ready(rdy_b), .dwell(dwell_b),
    .out(out_b), .cur_idx(idx_b), .wrap(wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t xa(input int idx, input bit act, input bit w, input bit r);
    exp_t e;
    e.out  = act ? (16'(1) << idx) : 16'h0000;
    e.idx  = 4'(idx);
    e.wrap = w;
    e.rdy  = r;
    return e;
  endfunction

  function automatic exp_t xb(input int idx, input bit act, input bit w);
    exp_t e;
    e.out  = act ? ~(16'(1) << idx) : 16'hFFFF;
    e.idx  = 4'(idx);
    e.wrap = w;
    e.rdy  = 1'b0;
    return e;
  endfunction

  // Queue expectations for the coming edge, then pop and compare once outputs settle.
  task automatic cyc(input string tag, input exp_t ea, input exp_t eb);
    exp_t a, b;
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk);
    #1;
    a = qa.pop_front();
    b = qb.pop_front();
    chk({tag, ".out"},    {24'h0, out},     {16'h0, a.out});
    chk({tag, ".idx"},    {29'h0, cur_idx}, {28'h0, a.idx});
    chk({tag, ".wrap"},   {31'h0, wrap},    {31'h0, a.wrap});
    chk({tag, ".rdy"},    {31'h0, sel_ready}, {31'h0, a.rdy});
    chk({tag, ".b_out"},  {16'h0, out_b},   {16'h0, b.out});
    chk({tag, ".b_idx"},  {28'h0, idx_b},   {28'h0, b.idx});
    chk({tag, ".b_wrap"}, {31'h0, wrap_b},  {31'h0, b.wrap});
    chk({tag, ".b_rdy"},  {31'h0, rdy_b},   {31'h0, b.rdy});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [10];
    seq = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};

    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0; dwell = 8'd2;
    en_b = 1'b0; mode_b = 1'b0; vld_b = 1'b0; sel_b = '0; dwell_b = 8'd0;

    // reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1; mode = i[0]; sel_valid = 1'b1; sel = 3'($urandom_range(7));
      en_b = 1'b1; mode_b = ~i[0];
      @(posedge clk);
      #1;
      chk("rst.out", {24'h0, out}, 32'h0);
      chk("rst.idx", {29'h0, cur_idx}, 32'h0);
      chk("rst.wrap", {31'h0, wrap}, 32'h0);
      chk("rst.rdy", {31'h0, sel_ready}, 32'h0);
      chk("rst.b_out", {16'h0, out_b}, 32'hFFFF);
    end
    enable = 1'b1; mode = 1'b0; sel_valid = 1'b0; sel = '0;
    en_b = 1'b0; mode_b = 1'b0;
    rst_n = 1'b1;

    // direct
    cyc("idle2dir", xa(0, 1, 0, 1), xb(0, 0, 0));
    sel = 3'd5; sel_valid = 1'b1;
    cyc("dir5", xa(5, 1, 0, 1), xb(0, 0, 0));
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cyc("sweep", xa(s, 1, 0, 1), xb(0, 0, 0));
    end
    sel_valid = 1'b0; sel = 3'd3;
    cyc("dir_hold", xa(7, 1, 0, 1), xb(0, 0, 0));
    sel = 3'd6; sel_valid = 1'b1;
    cyc("dir6", xa(6, 1, 0, 1), xb(0, 0, 0));

    // scan, dwell 2 from idx 6
    sel_valid = 1'b0; mode = 1'b1; dwell = 8'd2;
    for (int i = 0; i < 10; i++)
      cyc("scan_d2", xa(seq[i], 1, (i == 6), 0), xb(0, 0, 0));
    dwell = 8'd0;
    cyc("scan_d0a", xa(2, 1, 0, 0), xb(0, 0, 0));
    cyc("scan_d0b", xa(3, 1, 0, 0), xb(0, 0, 0));

    // enable drop at idx 3, then resume with full dwell
    enable = 1'b0;
    cyc("en_off1", xa(3, 0, 0, 0), xb(0, 0, 0));
    cyc("en_off2", xa(3, 0, 0, 0), xb(0, 0, 0));
    enable = 1'b1; dwell = 8'd2;
    cyc("resume0", xa(3, 1, 0, 0), xb(0, 0, 0));
    cyc("resume1", xa(3, 1, 0, 0), xb(0, 0, 0));
    cyc("resume2", xa(3, 1, 0, 0), xb(0, 0, 0));
    cyc("resume3", xa(4, 1, 0, 0), xb(0, 0, 0));
    dwell = 8'd0;
    cyc("run5", xa(5, 1, 0, 0), xb(0, 0, 0));
    cyc("run6", xa(6, 1, 0, 0), xb(0, 0, 0));
    cyc("run7", xa(7, 1, 0, 0), xb(0, 0, 0));
    cyc("run0", xa(0, 1, 1, 0), xb(0, 0, 0));
    cyc("run1", xa(1, 1, 0, 0), xb(0, 0, 0));

    // handshake ignored in scan, decided on pre-edge state
    dwell = 8'd7; sel = 3'd2; sel_valid = 1'b1;
    chk("scan_rdy", {31'h0, sel_ready}, 32'h0);
    cyc("scan_vld", xa(1, 1, 0, 0), xb(0, 0, 0));
    mode = 1'b0;
    cyc("scan2dir", xa(1, 1, 0, 1), xb(0, 0, 0));
    cyc("dir_acc2", xa(2, 1, 0, 1), xb(0, 0, 0));
    sel = 3'd4; mode = 1'b1;
    cyc("dir2scan_acc", xa(4, 1, 0, 0), xb(0, 0, 0));
    sel_valid = 1'b0; dwell = 8'd0;
    cyc("scan_after", xa(5, 1, 0, 0), xb(0, 0, 0));

    // 16-output active-low instance: full scan wrap
    enable = 1'b0;
    en_b = 1'b1; mode_b = 1'b1; dwell_b = 8'd0;
    cyc("b_entry", xa(5, 0, 0, 0), xb(0, 1, 0));
    for (int i = 1; i < 16; i++)
      cyc("b_scan", xa(5, 0, 0, 0), xb(i, 1, 0));
    cyc("b_wrap", xa(5, 0, 0, 0), xb(0, 1, 1));
    enable = 1'b1;
    cyc("b_after", xa(5, 1, 0, 0), xb(1, 1, 0));

    // async reset mid-cycle, then first edge behaves as IDLE
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.out", {24'h0, out}, 32'h0);
    chk("arst.idx", {29'h0, cur_idx}, 32'h0);
    chk("arst.rdy", {31'h0, sel_ready}, 32'h0);
    chk("arst.b_out", {16'h0, out_b}, 32'hFFFF);
    chk("arst.b_idx", {28'h0, idx_b}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post_rst0", xa(0, 1, 0, 0), xb(0, 1, 0));
    cyc("post_rst1", xa(1, 1, 0, 0), xb(1, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
